// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI mode-0 frame receiver that delivers NUM_CH*DATA_WIDTH-bit frames over a valid/ready output
//   clk, rst         : system clock, synchronous active-high reset
//   sclk, mosi, cs   : SPI slave pins (asynchronous to clk, cs active-low, MSB first)
//   m_data, m_valid  : received frame (channel 0 in the MSBs) and its valid flag
//   m_ready          : consumer accepts m_data when m_valid and m_ready are both high
//   err_short        : one-cycle pulse when cs rises before a full frame
//   err_overrun      : one-cycle pulse when a completed frame is dropped
//   frame_cnt        : count of frames accepted into m_data, wraps at 16 bits
module spi_frame_rx #(
    parameter  int DATA_WIDTH = 12,
    parameter  int NUM_CH     = 3,
    localparam int FRAME_BITS = NUM_CH * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs,
    output logic [FRAME_BITS-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  err_short,
    output logic                  err_overrun,
    output logic [15:0]           frame_cnt
);
    localparam int CW = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS, SYNC} state_t;

    state_t                state_q, state_d;
    logic [1:0]            sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                  sclk_prev_q, cs_prev_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  err_short_q, err_short_d, err_overrun_q, err_overrun_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  sclk_rise, cs_fall, cs_rise, done, accept;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign cs_fall   = ~cs_sync_q[1] & cs_prev_q;
    assign cs_rise   = cs_sync_q[1] & ~cs_prev_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        done        = 1'b0;
        err_short_d = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) begin
                cnt_d   = '0;
                shift_d = '0;
                state_d = SHIFT;
            end
            SHIFT: if (cs_rise) begin
                err_short_d = 1'b1;
                cnt_d       = '0;
                shift_d     = '0;
                state_d     = IDLE;
            end else if (sclk_rise) begin
                shift_d = {shift_q[FRAME_BITS-2:0], mosi_sync_q[1]};
                cnt_d   = cnt_q + CW'(1);
                // The frame is issued on the same edge that shifts in its last bit.
                if (cnt_q == CW'(FRAME_BITS - 1)) begin
                    done    = 1'b1;
                    state_d = WAIT_CS;
                end
            end
            WAIT_CS: if (cs_rise) state_d = IDLE;
            // Leaving only once cs is seen high guarantees a frame cut by reset is never resumed.
            SYNC: if (cs_sync_q[1]) state_d = IDLE;
            default: state_d = SYNC;
        endcase
    end

    // A held frame is only replaced when the consumer takes it in the same cycle.
    assign accept        = done & (~m_valid_q | m_ready);
    assign err_overrun_d = done & m_valid_q & ~m_ready;
    assign m_valid_d     = accept | (m_valid_q & ~m_ready);
    assign m_data_d      = accept ? shift_d : m_data_q;
    assign frame_cnt_d   = frame_cnt_q + 16'(accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SYNC;
            sclk_sync_q   <= '0;
            mosi_sync_q   <= '0;
            // cs resets low so SYNC waits for the real pin level before arming edge detection.
            cs_sync_q     <= '0;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b0;
            cnt_q         <= '0;
            shift_q       <= '0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            err_short_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= {sclk_sync_q[0], sclk};
            mosi_sync_q   <= {mosi_sync_q[0], mosi};
            cs_sync_q     <= {cs_sync_q[0], cs};
            sclk_prev_q   <= sclk_sync_q[1];
            cs_prev_q     <= cs_sync_q[1];
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            err_short_q   <= err_short_d;
            err_overrun_q <= err_overrun_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign err_short   = err_short_q;
    assign err_overrun = err_overrun_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: randomized self-checking bench for spi_frame_rx against a bit-queue frame model
module tb_spi_frame_rx;
    localparam int FB = 36;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          cs = 1'b1;
    logic          m_ready = 1'b1;
    logic [FB-1:0] m_data;
    logic          m_valid, err_short, err_overrun;
    logic [15:0]   frame_cnt;

    int            n_checks = 0;
    int            n_fail = 0;
    int            n_valid = 0;
    int            n_short = 0;
    int            n_ovr = 0;
    logic [FB-1:0] hs_q[$];
    time           t_last_rise = 0;
    time           t_valid = 0;
    logic          valid_prev = 1'b0;

    always #5 clk = ~clk;

    spi_frame_rx dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .err_short(err_short), .err_overrun(err_overrun), .frame_cnt(frame_cnt)
    );

    always @(negedge clk) begin
        valid_prev <= m_valid;
        if (m_valid && !valid_prev) t_valid <= $time;
        if (m_valid) n_valid <= n_valid + 1;
        if (m_valid && m_ready) hs_q.push_back(m_data);
        if (err_short) n_short <= n_short + 1;
        if (err_overrun) n_ovr <= n_ovr + 1;
    end

    function automatic logic [FB-1:0] expect_frame(input logic [63:0] v, input int n);
        bit q[$];
        logic [FB-1:0] r = '0;
        for (int i = 0; i < n; i++) q.push_back(v[n-1-i]);
        for (int i = 0; i < FB && i < q.size(); i++) r = r * 2 + FB'(q[i]);
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(6);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = v[n-1-i];
            tick(4);
            sclk = 1'b1;
            t_last_rise = $time;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [63:0] v, input int n);
        cs = 1'b0;
        tick(4);
        send_bits(v, n);
        tick(4);
        cs = 1'b1;
        tick(12);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", m_valid); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", m_data); end
        n_checks++; if (frame_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", frame_cnt); end
        n_checks++; if (err_short !== 1'b0) begin n_fail++; $display("FAIL reset_short: got %0h want 0", err_short); end
        n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %0h want 0", err_overrun); end
    endtask

    task automatic test_basic();
        int nv = n_valid, ns = n_short, no = n_ovr, b = hs_q.size();
        m_ready = 1'b1;
        send_frame(64'hABC123456, FB);
        n_checks++; if (m_data !== 36'hABC123456) begin n_fail++; $display("FAIL basic_data: got %h want abc123456", m_data); end
        n_checks++; if (hs_q.size() != b + 1) begin n_fail++; $display("FAIL basic_hs: got %0d want %0d", hs_q.size() - b, 1); end
        n_checks++; if (n_valid - nv != 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", n_valid - nv); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", frame_cnt); end
        n_checks++; if (n_short != ns || n_ovr != no) begin n_fail++; $display("FAIL basic_err: got short %0d ovr %0d want 0 0", n_short - ns, n_ovr - no); end
        n_checks++; if (!(t_valid > t_last_rise && t_valid - t_last_rise <= 50)) begin n_fail++; $display("FAIL basic_latency: got %0t want <= 50ns", t_valid - t_last_rise); end
    endtask

    task automatic test_overrun();
        logic [63:0] a = rand64(), c = rand64();
        int no, b;
        do_reset();
        no = n_ovr;
        m_ready = 1'b0;
        send_frame(a, FB);
        send_frame(c, FB);
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %0h want 1", m_valid); end
        n_checks++; if (m_data !== expect_frame(a, FB)) begin n_fail++; $display("FAIL ovr_data: got %h want %h", m_data, expect_frame(a, FB)); end
        n_checks++; if (n_ovr - no != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr - no); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL ovr_cnt: got %0d want 1", frame_cnt); end
        b = hs_q.size();
        m_ready = 1'b1;
        tick(1);
        tick(1);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain_valid: got %0h want 0", m_valid); end
        n_checks++; if (hs_q.size() != b + 1 || hs_q[hs_q.size()-1] !== expect_frame(a, FB)) begin n_fail++; $display("FAIL ovr_drain_data: got %0d handshakes want 1 of %h", hs_q.size() - b, expect_frame(a, FB)); end
    endtask

    task automatic test_short();
        int nv, ns;
        do_reset();
        nv = n_valid;
        ns = n_short;
        m_ready = 1'b1;
        send_frame(rand64(), 20);
        n_checks++; if (n_short - ns != 1) begin n_fail++; $display("FAIL short_pulse: got %0d want 1", n_short - ns); end
        n_checks++; if (n_valid != nv) begin n_fail++; $display("FAIL short_valid: got %0d want 0", n_valid - nv); end
        send_frame(64'hFFF000FFF, FB);
        n_checks++; if (m_data !== 36'hFFF000FFF) begin n_fail++; $display("FAIL short_next_data: got %h want fff000fff", m_data); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL short_next_cnt: got %0d want 1", frame_cnt); end
        n_checks++; if (n_short - ns != 1) begin n_fail++; $display("FAIL short_next_err: got %0d want 1", n_short - ns); end
    endtask

    task automatic test_long();
        logic [63:0] v = rand64();
        int nv, ns, no;
        do_reset();
        nv = n_valid;
        ns = n_short;
        no = n_ovr;
        send_frame(v, 40);
        n_checks++; if (m_data !== expect_frame(v, 40)) begin n_fail++; $display("FAIL long_data: got %h want %h", m_data, expect_frame(v, 40)); end
        n_checks++; if (n_valid - nv != 1) begin n_fail++; $display("FAIL long_valid: got %0d want 1", n_valid - nv); end
        n_checks++; if (n_short != ns || n_ovr != no) begin n_fail++; $display("FAIL long_err: got short %0d ovr %0d want 0 0", n_short - ns, n_ovr - no); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL long_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_rst_mid();
        logic [63:0] v = rand64(), w = rand64();
        int nv, ns, no;
        do_reset();
        nv = n_valid;
        ns = n_short;
        no = n_ovr;
        cs = 1'b0;
        tick(4);
        send_bits(v, 10);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        send_bits(v, 26);
        tick(4);
        cs = 1'b1;
        tick(12);
        n_checks++; if (n_valid != nv) begin n_fail++; $display("FAIL rstmid_valid: got %0d want 0", n_valid - nv); end
        n_checks++; if (n_short != ns || n_ovr != no) begin n_fail++; $display("FAIL rstmid_err: got short %0d ovr %0d want 0 0", n_short - ns, n_ovr - no); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", frame_cnt); end
        send_frame(w, FB);
        n_checks++; if (m_data !== expect_frame(w, FB)) begin n_fail++; $display("FAIL rstmid_next_data: got %h want %h", m_data, expect_frame(w, FB)); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL rstmid_next_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_wrap();
        logic [63:0] v = rand64();
        do_reset();
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        tick(1);
        release dut.frame_cnt_q;
        tick(2);
        n_checks++; if (frame_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", frame_cnt); end
        send_frame(v, FB);
        n_checks++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_cnt: got %h want 0000", frame_cnt); end
        n_checks++; if (m_data !== expect_frame(v, FB)) begin n_fail++; $display("FAIL wrap_data: got %h want %h", m_data, expect_frame(v, FB)); end
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] exp_q[$];
        logic [63:0] v;
        int b;
        do_reset();
        m_ready = 1'b1;
        b = hs_q.size();
        for (int k = 0; k < 6; k++) begin
            v = rand64();
            exp_q.push_back(expect_frame(v, FB));
            send_frame(v, FB);
        end
        n_checks++; if (hs_q.size() - b != 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", hs_q.size() - b); end
        for (int k = 0; k < 6 && b + k < hs_q.size(); k++) begin
            n_checks++; if (hs_q[b+k] !== exp_q[k]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", k, hs_q[b+k], exp_q[k]); end
        end
        n_checks++; if (frame_cnt !== 16'd6) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 6", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_short();
        test_long();
        test_rst_mid();
        test_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
